// File: rtl/band_seq_ctrl.sv
// band_seq_ctrl: write/read pointer sequencing for a circular stereo sample
// buffer feeding a bank of band FIRs. Each completed TAPS-sample window
// triggers one read burst of TAPS+1 cycles followed by one GAP cycle that
// marks the FIR sums final.
//
// state | meaning
// IDLE  | no burst running; waiting for a pending window request
// SEQ   | burst in progress, rd_ptr walks the window oldest-first
// GAP   | one-cycle separator, burst_done asserted
module band_seq_ctrl #(
  parameter int DEPTH = 1024,
  parameter int TAPS  = 1021,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wrt_smpl,
  input  logic             clr_buf,
  output logic             wrt_en,
  output logic [PTR_W-1:0] wrt_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic             sequencing,
  output logic             burst_done,
  output logic             overrun
);

  localparam int CNT_W = $clog2(TAPS + 1);
  localparam logic [CNT_W-1:0] TAPS_C  = CNT_W'(TAPS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef enum logic [1:0] {IDLE, SEQ, GAP} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] new_ptr_q, new_ptr_d;
  logic [PTR_W-1:0] old_ptr_q, old_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] seq_cnt_q, seq_cnt_d;
  logic             pend_q, pend_d;
  logic             seq_q, seq_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic             wr;
  logic             set_req;
  logic             launch;

  assign wrt_en     = wrt_smpl & ~clr_buf;
  assign wrt_ptr    = new_ptr_q;
  assign rd_ptr     = rd_ptr_q;
  assign sequencing = seq_q;
  assign burst_done = done_q;
  assign overrun    = ovr_q;

  // State register; reset clears everything immediately, aborting any burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      new_ptr_q <= '0;
      old_ptr_q <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      seq_cnt_q <= '0;
      pend_q    <= 1'b0;
      seq_q     <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      new_ptr_q <= new_ptr_d;
      old_ptr_q <= old_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      seq_cnt_q <= seq_cnt_d;
      pend_q    <= pend_d;
      seq_q     <= seq_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
    end
  end

  // Window bookkeeping, request handling and burst FSM next-state logic.
  always_comb begin
    state_d   = state_q;
    new_ptr_d = new_ptr_q;
    old_ptr_d = old_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    seq_cnt_d = seq_cnt_q;
    pend_d    = pend_q;
    ovr_d     = ovr_q;
    launch    = 1'b0;
    wr        = wrt_smpl & ~clr_buf;

    // A write into a full window slides its base; the fill count saturates.
    if (wr) begin
      new_ptr_d = new_ptr_q + PTR_ONE;
      if (cnt_q == TAPS_C) begin
        old_ptr_d = old_ptr_q + PTR_ONE;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
    set_req = wr && (cnt_d == TAPS_C);

    case (state_q)
      IDLE: begin
        if (pend_q) launch = 1'b1;
      end
      SEQ: begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (seq_cnt_q == '0) begin
          state_d = GAP;
        end else begin
          seq_cnt_d = seq_cnt_q - CNT_ONE;
        end
      end
      GAP: begin
        if (pend_q) launch = 1'b1;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Launch reads from the post-slide base, so a same-edge sample is
    // already part of this burst and its request is absorbed here.
    if (launch) begin
      state_d   = SEQ;
      rd_ptr_d  = old_ptr_d;
      seq_cnt_d = TAPS_C;
      pend_d    = 1'b0;
    end else if (set_req) begin
      if (pend_q) ovr_d = 1'b1;
      pend_d = 1'b1;
    end

    if (clr_buf) begin
      state_d   = IDLE;
      new_ptr_d = '0;
      old_ptr_d = '0;
      rd_ptr_d  = '0;
      cnt_d     = '0;
      seq_cnt_d = '0;
      pend_d    = 1'b0;
      ovr_d     = 1'b0;
    end

    seq_d  = (state_d == SEQ);
    done_d = (state_d == GAP);
  end

endmodule

// File: tb/tb_band_seq_ctrl.sv
// Testbench for band_seq_ctrl (DEPTH=8, TAPS=4): directed scenarios with
// literal expectations plus randomized traffic, all cross-checked every
// cycle against a sample-count based reference model.
module tb_band_seq_ctrl;
  localparam int DEPTH = 8;
  localparam int TAPS  = 4;
  localparam int PTR_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wrt_smpl = 1'b0;
  logic             clr_buf = 1'b0;
  logic             wrt_en;
  logic [PTR_W-1:0] wrt_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             sequencing;
  logic             burst_done;
  logic             overrun;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  band_seq_ctrl #(.DEPTH(DEPTH), .TAPS(TAPS), .PTR_W(PTR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wrt_smpl   (wrt_smpl),
    .clr_buf    (clr_buf),
    .wrt_en     (wrt_en),
    .wrt_ptr    (wrt_ptr),
    .rd_ptr     (rd_ptr),
    .sequencing (sequencing),
    .burst_done (burst_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Model: nwr = samples written since clear; pos = 0 idle, 1..TAPS+1 burst
  // cycle number, TAPS+2 the done cycle; base = oldest sample of the burst.
  typedef struct packed {
    int   nwr;
    logic pend;
    logic ovr;
    int   pos;
    int   base;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t step(input mdl_t s, input logic wr, input logic clr);
    mdl_t n;
    bit   full_now;
    bit   start;
    n = s;
    if (clr) return '0;
    full_now = 1'b0;
    if (wr) begin
      n.nwr = s.nwr + 1;
      full_now = (n.nwr >= TAPS);
    end
    start = s.pend && (s.pos == 0 || s.pos == TAPS + 2);
    if (start) begin
      n.pos  = 1;
      n.base = (n.nwr - TAPS) % DEPTH;
      n.pend = 1'b0;
    end else begin
      if (s.pos == TAPS + 2) n.pos = 0;
      else if (s.pos != 0)   n.pos = s.pos + 1;
      if (full_now) begin
        if (s.pend) n.ovr = 1'b1;
        n.pend = 1'b1;
      end
    end
    return n;
  endfunction

  // Reference model advances on the same edges as the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= step(m, wrt_smpl, clr_buf);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("m_sequencing", 32'(sequencing), 32'(m.pos >= 1 && m.pos <= TAPS + 1));
      chk("m_burst_done", 32'(burst_done), 32'(m.pos == TAPS + 2));
      chk("m_wrt_ptr", 32'(wrt_ptr), 32'(m.nwr % DEPTH));
      chk("m_overrun", 32'(overrun), 32'(m.ovr));
      chk("m_wrt_en", 32'(wrt_en), 32'(wrt_smpl & ~clr_buf));
      if (m.pos >= 1 && m.pos <= TAPS)
        chk("m_rd_ptr", 32'(rd_ptr), 32'((m.base + m.pos - 1) % DEPTH));
    end
  end

  task automatic strobe();
    @(posedge clk); #1 wrt_smpl = 1'b1;
    @(posedge clk); #1 wrt_smpl = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values while rst_n is held low
    #2;
    chk("rst_wrt_ptr", 32'(wrt_ptr), 32'd0);
    chk("rst_rd_ptr", 32'(rd_ptr), 32'd0);
    chk("rst_sequencing", 32'(sequencing), 32'd0);
    chk("rst_burst_done", 32'(burst_done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    chk_en = 1'b1;
    idle_cycles(3);

    // Fill phase: three samples, no burst
    for (int i = 0; i < 3; i++) begin
      strobe();
      idle_cycles(19);
      chk("fill_wrt_ptr", 32'(wrt_ptr), 32'(i + 1));
      chk("fill_sequencing", 32'(sequencing), 32'd0);
    end

    // First full window: burst reads 0..3, then one done pulse
    strobe();
    @(negedge clk);
    chk("first_pre_seq", 32'(sequencing), 32'd0);
    for (int i = 0; i < TAPS + 1; i++) begin
      @(negedge clk);
      chk("first_seq", 32'(sequencing), 32'd1);
      if (i < TAPS) chk("first_rd_ptr", 32'(rd_ptr), 32'(i));
    end
    @(negedge clk);
    chk("first_done", 32'(burst_done), 32'd1);
    chk("first_gap_seq", 32'(sequencing), 32'd0);
    @(negedge clk);
    chk("first_done_clear", 32'(burst_done), 32'd0);
    idle_cycles(10);

    // Sliding window with pointer wrap
    for (int i = 0; i < 10; i++) begin
      strobe();
      idle_cycles(19);
    end
    chk("slide_wrt_ptr", 32'(wrt_ptr), 32'd6);
    chk("slide_overrun", 32'(overrun), 32'd0);

    // Back-to-back: one extra sample during a burst is queued, no overrun
    strobe();
    @(posedge clk);
    strobe();
    idle_cycles(20);
    chk("b2b_overrun", 32'(overrun), 32'd0);

    // Two extra samples during one burst raise overrun
    strobe();
    strobe();
    strobe();
    idle_cycles(20);
    chk("ovr_overrun", 32'(overrun), 32'd1);

    // Flush in the third burst cycle aborts the burst
    strobe();
    @(posedge clk); @(posedge clk); @(posedge clk);
    #1 clr_buf = 1'b1;
    @(posedge clk); #1 clr_buf = 1'b0;
    @(negedge clk);
    chk("clr_seq", 32'(sequencing), 32'd0);
    chk("clr_wrt_ptr", 32'(wrt_ptr), 32'd0);
    chk("clr_done", 32'(burst_done), 32'd0);
    chk("clr_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    chk("clr_no_done", 32'(burst_done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      strobe();
      idle_cycles(19);
    end
    chk("refill_no_seq", 32'(sequencing), 32'd0);
    strobe();
    idle_cycles(20);

    // Randomized traffic including occasional flushes
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      wrt_smpl = ($urandom_range(0, 3) == 0);
      clr_buf  = ($urandom_range(0, 79) == 0);
    end
    @(posedge clk); #1 wrt_smpl = 1'b0; clr_buf = 1'b0;
    idle_cycles(20);

    // Reset asserted mid-burst
    @(posedge clk); #1 clr_buf = 1'b1;
    @(posedge clk); #1 clr_buf = 1'b0;
    for (int i = 0; i < 3; i++) strobe();
    idle_cycles(20);
    strobe();
    @(posedge clk); @(posedge clk);
    #3;
    chk("pre_rst_seq", 32'(sequencing), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_seq", 32'(sequencing), 32'd0);
    chk("arst_wrt_ptr", 32'(wrt_ptr), 32'd0);
    chk("arst_rd_ptr", 32'(rd_ptr), 32'd0);
    chk("arst_done", 32'(burst_done), 32'd0);
    chk("arst_overrun", 32'(overrun), 32'd0);
    idle_cycles(2);
    chk("arst_hold_done", 32'(burst_done), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Refill after reset: three samples produce no burst, the fourth does
    for (int i = 0; i < 3; i++) begin
      strobe();
      idle_cycles(19);
    end
    chk("post_rst_no_seq", 32'(sequencing), 32'd0);
    strobe();
    idle_cycles(3);
    chk("post_rst_seq", 32'(sequencing), 32'd1);
    idle_cycles(15);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/band_seq_ctrl.md
BAND_SEQ_CTRL -- requirements
Module: band_seq_ctrl

Interface
REQ-001 Parameter DEPTH, default 1024, sample-buffer depth; SHALL be a power of 2.
REQ-002 Parameter TAPS, default 1021, samples per convolution window; SHALL satisfy 2 <= TAPS <= DEPTH-3.
REQ-003 Parameter PTR_W, default $clog2(DEPTH), pointer width.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 wrt_smpl  input  1  one-cycle strobe: new stereo sample present at buffer write-data port.
REQ-007 clr_buf  input  1  synchronous flush of buffer state.
REQ-008 wrt_en  output  1  buffer write enable; equals wrt_smpl combinationally, forced 0 when clr_buf=1.
REQ-009 wrt_ptr  output  PTR_W  buffer write address (new_ptr register).
REQ-010 rd_ptr  output  PTR_W  buffer read address; buffer read is synchronous, data valid one cycle later.
REQ-011 sequencing  output  1  registered; drives sequencing input of every band FIR.
REQ-012 burst_done  output  1  registered one-cycle pulse: FIR sums final, downstream may latch.
REQ-013 overrun  output  1  sticky error flag.

Function
REQ-014 Internal state: new_ptr, old_ptr (PTR_W), fill count cnt (0..TAPS, saturating), pend flag, SEQ_LEN counter, FSM {IDLE, SEQ, GAP}.
REQ-015 On wrt_smpl=1: write at new_ptr; new_ptr <= new_ptr+1 mod DEPTH; cnt <= min(cnt+1, TAPS).
REQ-016 On wrt_smpl=1 with cnt==TAPS before the edge: old_ptr <= old_ptr+1 mod DEPTH (window slides).
REQ-017 On wrt_smpl=1 with post-write cnt==TAPS: pend <= 1; no request while cnt < TAPS (fill phase).
REQ-018 IDLE: sequencing=0; if pend=1 -> SEQ next edge, rd_ptr <= old_ptr (value after any same-edge slide), pend <= 0.
REQ-019 SEQ: sequencing=1 for exactly SEQ_LEN=TAPS+1 consecutive cycles; rd_ptr increments by 1 mod DEPTH each SEQ cycle; rd_ptr value in last SEQ cycle is don't-care.
REQ-020 Reads in SEQ cover old_ptr..old_ptr+TAPS-1 mod DEPTH, oldest first; newest sample is last read.
REQ-021 SEQ -> GAP after SEQ_LEN cycles; GAP lasts exactly 1 cycle with sequencing=0 and burst_done=1.
REQ-022 GAP -> SEQ if pend=1 (same rd_ptr load rule as REQ-018), else -> IDLE; sequencing SHALL never be high on two bursts without an intervening low cycle.
REQ-023 wrt_smpl during SEQ/GAP: write and pointer updates proceed per REQ-015..017; the burst's rd_ptr sequence is unaffected.
REQ-024 wrt_smpl arriving while pend=1 and sample would set pend again: overrun <= 1; pend stays 1 (one request retained).
REQ-025 wrt_smpl and FSM IDLE->SEQ on the same edge: slide applied first, burst base includes the new sample.
REQ-026 clr_buf=1: next edge new_ptr=old_ptr=rd_ptr=0, cnt=0, pend=0, overrun=0, FSM=IDLE, sequencing=0, burst_done=0; overrides wrt_smpl that cycle.
REQ-027 Latency: wrt_smpl edge completing a window -> sequencing high 1 cycle later when FSM idle.

Reset
REQ-028 rst_n=0 SHALL immediately force: wrt_ptr=0, rd_ptr=0, sequencing=0, burst_done=0, overrun=0, cnt=0, pend=0, old_ptr=0, FSM=IDLE.
REQ-029 Reset asserted mid-burst SHALL drop sequencing asynchronously; no burst_done is produced for the aborted burst.
REQ-030 After rst_n rises, a full TAPS-sample refill SHALL precede the next burst.

Verification (bench params DEPTH=8, TAPS=4)
REQ-031 Fill: 3 wrt_smpl strobes spaced 20 cycles -> wrt_ptr 0,1,2,3; sequencing stays 0.
REQ-032 First window: 4th strobe -> sequencing high 5 cycles, rd_ptr 0,1,2,3,(x); burst_done pulse in following cycle.
REQ-033 Slide/wrap: 10 further strobes spaced 20 cycles -> each burst base = previous+1 mod 8; wrt_ptr wraps 7->0; no overrun.
REQ-034 Back-to-back: strobe in 2nd SEQ cycle -> current burst unchanged, exactly one GAP cycle, next burst base +1, overrun=0; two strobes in one burst -> overrun=1.
REQ-035 clr_buf in 3rd SEQ cycle -> sequencing 0 next cycle, wrt_ptr=0, no burst_done; 4 new strobes required before next burst.
REQ-036 rst_n low in SEQ -> sequencing 0 same cycle, all outputs at REQ-028 values.
